// File: rtl/int_entry_seq.sv
// Interrupt-entry sequencer: on an int_req rising edge, pushes PC high/low and flags
// to the stack, then redirects the PC to the interrupt vector.
module int_entry_seq #(
  parameter int              PC_W     = 32,
  parameter int              DATA_W   = 16,
  parameter int              FLAG_W   = 3,
  parameter logic [PC_W-1:0] VEC_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              int_req,
  input  logic              stall_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [FLAG_W-1:0] flags_in,
  output logic              int_out,
  output logic [1:0]        count,
  output logic              mem_write,
  output logic              sp_dec,
  output logic [DATA_W-1:0] wr_data,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_next,
  output logic              int_ack
);

  typedef enum logic [2:0] {
    IDLE,
    PUSH_HI,
    PUSH_LO,
    PUSH_FL,
    VECTOR
  } state_t;

  state_t            state;
  logic              req_q;
  logic              pending;
  logic [PC_W-1:0]   pc_r;
  logic [FLAG_W-1:0] fl_r;
  logic              push_q;
  logic              vec_q;
  logic              int_q;
  logic [1:0]        count_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [PC_W-1:0]   pc_next_q;
  logic              req_edge;
  logic              start;

  assign req_edge = int_req & ~req_q;
  assign start    = (state == IDLE) & (pending | req_edge) & ~stall_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_q     <= 1'b0;
      pending   <= 1'b0;
      pc_r      <= '0;
      fl_r      <= '0;
      push_q    <= 1'b0;
      vec_q     <= 1'b0;
      int_q     <= 1'b0;
      count_q   <= 2'd0;
      wr_data_q <= '0;
      pc_next_q <= '0;
    end else begin
      req_q <= int_req;
      // A start consumes both the latched request and any coincident edge
      if (start)
        pending <= 1'b0;
      else if (req_edge)
        pending <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            pc_r      <= pc_in;
            fl_r      <= flags_in;
            state     <= PUSH_HI;
            int_q     <= 1'b1;
            count_q   <= 2'd3;
            push_q    <= 1'b1;
            wr_data_q <= pc_in[PC_W-1:DATA_W];
          end
        end
        PUSH_HI: begin
          if (!stall_in) begin
            state     <= PUSH_LO;
            count_q   <= 2'd2;
            wr_data_q <= pc_r[DATA_W-1:0];
          end
        end
        PUSH_LO: begin
          if (!stall_in) begin
            state     <= PUSH_FL;
            count_q   <= 2'd1;
            wr_data_q <= {{(DATA_W-FLAG_W){1'b0}}, fl_r};
          end
        end
        PUSH_FL: begin
          if (!stall_in) begin
            state     <= VECTOR;
            count_q   <= 2'd0;
            push_q    <= 1'b0;
            wr_data_q <= '0;
            vec_q     <= 1'b1;
            pc_next_q <= VEC_ADDR;
          end
        end
        VECTOR: begin
          if (!stall_in) begin
            state     <= IDLE;
            int_q     <= 1'b0;
            vec_q     <= 1'b0;
            pc_next_q <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are suppressed while stalled so each step is issued exactly once
  assign mem_write = push_q & ~stall_in;
  assign sp_dec    = mem_write;
  assign pc_load   = vec_q & ~stall_in;
  assign int_ack   = pc_load;
  assign wr_data   = wr_data_q;
  assign pc_next   = pc_next_q;
  assign count     = count_q;
  assign int_out   = int_q;

endmodule

// File: tb/tb_int_entry_seq.sv
// Testbench for int_entry_seq: directed scenarios plus random traffic, all checked
// every cycle against a queue-of-beats reference model.
module tb_int_entry_seq;

  localparam logic [31:0] VEC = 32'h0000_8000;

  logic        clk;
  logic        rst;
  logic        int_req;
  logic        stall_in;
  logic [31:0] pc_in;
  logic [2:0]  flags_in;
  logic        int_out;
  logic [1:0]  count;
  logic        mem_write;
  logic        sp_dec;
  logic [15:0] wr_data;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        int_ack;

  int n_checks = 0;
  int n_errors = 0;

  int_entry_seq #(
    .PC_W(32), .DATA_W(16), .FLAG_W(3), .VEC_ADDR(VEC)
  ) dut (
    .clk(clk), .rst(rst), .int_req(int_req), .stall_in(stall_in),
    .pc_in(pc_in), .flags_in(flags_in), .int_out(int_out), .count(count),
    .mem_write(mem_write), .sp_dec(sp_dec), .wr_data(wr_data),
    .pc_load(pc_load), .pc_next(pc_next), .int_ack(int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an interrupt expands into a queue of four bus beats; a beat
  // retires on every unstalled cycle, and requests arriving while busy latch once.
  typedef struct packed {
    logic        wr;
    logic [15:0] data;
    logic [1:0]  cnt;
  } beat_t;

  beat_t m_q[$];
  bit    m_pending = 1'b0;
  bit    m_prev    = 1'b0;
  bit    m_edge;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_pending = 1'b0;
      m_prev    = 1'b0;
    end else begin
      m_edge = int_req && !m_prev;
      m_prev = int_req;
      if (m_q.size() == 0) begin
        if ((m_pending || m_edge) && !stall_in) begin
          m_q.push_back(beat_t'{wr: 1'b1, data: pc_in[31:16], cnt: 2'd3});
          m_q.push_back(beat_t'{wr: 1'b1, data: pc_in[15:0], cnt: 2'd2});
          m_q.push_back(beat_t'{wr: 1'b1, data: {13'd0, flags_in}, cnt: 2'd1});
          m_q.push_back(beat_t'{wr: 1'b0, data: 16'd0, cnt: 2'd0});
          m_pending = 1'b0;
        end else if (m_edge) begin
          m_pending = 1'b1;
        end
      end else begin
        if (m_edge) m_pending = 1'b1;
        if (!stall_in) void'(m_q.pop_front());
      end
    end
  end

  // {int_out, count, mem_write, sp_dec, wr_data, pc_load, pc_next, int_ack}
  logic [54:0] got_v;
  logic [54:0] exp_v;

  task automatic applyStimulus(input logic r, input logic q, input logic s,
                               input logic [31:0] pc, input logic [2:0] fl);
    bit    busy;
    beat_t h;
    @(negedge clk);
    rst      = r;
    int_req  = q;
    stall_in = s;
    pc_in    = pc;
    flags_in = fl;
    #1;
    busy = (m_q.size() != 0);
    h    = busy ? m_q[0] : beat_t'(0);
    exp_v = {busy, h.cnt, busy && h.wr && !s, busy && h.wr && !s,
             (busy && h.wr) ? h.data : 16'd0,
             busy && !h.wr && !s, (busy && !h.wr) ? VEC : 32'd0,
             busy && !h.wr && !s};
    got_v = {int_out, count, mem_write, sp_dec,
             (busy && h.wr) ? wr_data : 16'd0,
             pc_load, pc_next, int_ack};
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, $urandom, 3'($urandom));
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("[TB] FAIL idle cycle %0d: got %h expected %h", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'($urandom), 1'($urandom), $urandom, 3'($urandom));
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("[TB] FAIL reset cycle %0d: got %h expected %h", i, got_v, exp_v);
      end
    end
    n_checks++;
    if ({int_out, count, mem_write, pc_load, int_ack, pc_next} !== 38'd0) begin
      n_errors++;
      $display("[TB] FAIL reset_outputs: got int_out=%b count=%0d mw=%b pl=%b ack=%b pc_next=%h expected all 0",
               int_out, count, mem_write, pc_load, int_ack, pc_next);
    end
  endtask

  task automatic test_basic();
    logic [15:0] writes[$];
    int acks = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_1234, 3'b101);
      else        applyStimulus(1'b0, 1'b0, 1'b0, $urandom, 3'($urandom));
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("[TB] FAIL basic cycle %0d: got %h expected %h", i, got_v, exp_v);
      end
      if (mem_write) writes.push_back(wr_data);
      if (int_ack) acks++;
    end
    n_checks++;
    if (writes.size() != 3 || writes[0] !== 16'h0000 || writes[1] !== 16'h1234 || writes[2] !== 16'h0005) begin
      n_errors++;
      $display("[TB] FAIL basic_writes: got %p expected '{0000,1234,0005}", writes);
    end
    n_checks++;
    if (acks != 1) begin
      n_errors++;
      $display("[TB] FAIL basic_acks: got %0d expected 1", acks);
    end
  endtask

  task automatic test_stall();
    int load_at = -1;
    int hits = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, i == 0, (i == 2) || (i == 3), 32'h0000_1234, 3'b010);
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("[TB] FAIL stall cycle %0d: got %h expected %h", i, got_v, exp_v);
      end
      if ((i == 2 || i == 3) && (count !== 2'd2 || mem_write !== 1'b0)) begin
        n_errors++;
        $display("[TB] FAIL stall_hold cycle %0d: got count=%0d mw=%b expected count=2 mw=0", i, count, mem_write);
      end
      if (i == 2 || i == 3) n_checks++;
      if (mem_write && wr_data == 16'h1234) hits++;
      if (pc_load) load_at = i;
    end
    n_checks++;
    if (hits != 1 || load_at != 6) begin
      n_errors++;
      $display("[TB] FAIL stall_timing: got lo_writes=%0d load_cycle=%0d expected 1 and 6", hits, load_at);
    end
  endtask

  task automatic test_queued();
    int acks = 0;
    int gap_int = -1;
    // edges in PUSH_LO (queued) and VECTOR (dropped while one is pending)
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, (i == 0) || (i == 2) || (i == 4), 1'b0, $urandom, 3'($urandom));
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("[TB] FAIL queued_a cycle %0d: got %h expected %h", i, got_v, exp_v);
      end
      if (int_ack) acks++;
    end
    n_checks++;
    if (acks != 2) begin
      n_errors++;
      $display("[TB] FAIL queued_a_acks: got %0d expected 2", acks);
    end
    idle_cycles(2);
    acks = 0;
    // edge in PUSH_FL queues a second sequence after one IDLE cycle
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, (i == 0) || (i == 3), 1'b0, $urandom, 3'($urandom));
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("[TB] FAIL queued_b cycle %0d: got %h expected %h", i, got_v, exp_v);
      end
      if (int_ack) acks++;
      if (i == 5) gap_int = int_out;
    end
    n_checks++;
    if (acks != 2 || gap_int != 0) begin
      n_errors++;
      $display("[TB] FAIL queued_b: got acks=%0d gap_int_out=%0d expected 2 and 0", acks, gap_int);
    end
  endtask

  task automatic test_level();
    int acks = 0;
    for (int i = 0; i < 26; i++) begin
      applyStimulus(1'b0, i < 20, 1'b0, $urandom, 3'($urandom));
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("[TB] FAIL level cycle %0d: got %h expected %h", i, got_v, exp_v);
      end
      if (int_ack) acks++;
    end
    n_checks++;
    if (acks != 1) begin
      n_errors++;
      $display("[TB] FAIL level_acks: got %0d expected 1", acks);
    end
  endtask

  task automatic test_reset_mid();
    int early_loads = 0;
    int acks = 0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(i == 2, (i == 0) || (i == 8), 1'b0, $urandom, 3'($urandom));
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("[TB] FAIL reset_mid cycle %0d: got %h expected %h", i, got_v, exp_v);
      end
      if (i == 3) begin
        n_checks++;
        if ({int_out, count, mem_write, pc_load} !== 5'd0) begin
          n_errors++;
          $display("[TB] FAIL reset_mid_clear: got int_out=%b count=%0d mw=%b pl=%b expected all 0",
                   int_out, count, mem_write, pc_load);
        end
      end
      if (pc_load && i < 8) early_loads++;
      if (int_ack) acks++;
    end
    n_checks++;
    if (early_loads != 0 || acks != 1) begin
      n_errors++;
      $display("[TB] FAIL reset_mid_after: got early_loads=%0d acks=%0d expected 0 and 1", early_loads, acks);
    end
  endtask

  task automatic test_stalled_start();
    logic [31:0] p = $urandom;
    logic [2:0]  f = 3'($urandom_range(0, 7));
    logic [15:0] writes[$];
    for (int i = 0; i < 10; i++) begin
      if (i == 3) applyStimulus(1'b0, 1'b0, 1'b0, p, f);
      else        applyStimulus(1'b0, i == 0, i < 3, $urandom, 3'($urandom));
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("[TB] FAIL stalled_start cycle %0d: got %h expected %h", i, got_v, exp_v);
      end
      if (i < 4) begin
        n_checks++;
        if (int_out !== 1'b0 || count !== 2'd0) begin
          n_errors++;
          $display("[TB] FAIL stalled_start_idle cycle %0d: got int_out=%b count=%0d expected 0 0", i, int_out, count);
        end
      end
      if (mem_write) writes.push_back(wr_data);
    end
    n_checks++;
    if (writes.size() != 3 || writes[0] !== p[31:16] || writes[1] !== p[15:0] || writes[2] !== {13'd0, f}) begin
      n_errors++;
      $display("[TB] FAIL stalled_start_capture: got %p expected pc=%h flags=%0d", writes, p, f);
    end
  endtask

  task automatic test_random();
    logic q = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 15) q = ~q;
      applyStimulus($urandom_range(0, 99) < 2, q, $urandom_range(0, 99) < 25,
                    $urandom, 3'($urandom));
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("[TB] FAIL random cycle %0d: got %h expected %h", i, got_v, exp_v);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    int_req  = 1'b0;
    stall_in = 1'b0;
    pc_in    = '0;
    flags_in = '0;
    test_reset();
    idle_cycles(2);
    test_basic();
    idle_cycles(2);
    test_stall();
    idle_cycles(2);
    test_queued();
    idle_cycles(2);
    test_level();
    idle_cycles(2);
    test_reset_mid();
    idle_cycles(2);
    test_stalled_start();
    idle_cycles(2);
    test_random();
    idle_cycles(8);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/int_entry_seq.md
Name: int_entry_seq

Overview:
- Interrupt-entry sequencer. Generates the `int`/`count` pair consumed by the hazard detection unit.
- Detects an external interrupt request and walks a fixed 4-step sequence: push PC high half, push PC low half, push flags, redirect PC to the vector.
- Sits beside the decode/memory stages and drives stack writes plus the PC redirect.

Parameters:
- PC_W, 32, program-counter width (must equal 2*DATA_W).
- DATA_W, 16, stack/memory word width.
- FLAG_W, 3, CCR flag width (zero-extended to DATA_W when pushed).
- VEC_ADDR, 32'h0000_0000, PC value loaded at end of sequence.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- int_req  in  1  external interrupt request, level; rising edge triggers.
- stall_in  in  1  pipeline stall from HDU; freezes the sequencer.
- pc_in  in  PC_W  return PC (next unexecuted instruction), sampled at sequence start.
- flags_in  in  FLAG_W  current flags, sampled at sequence start.
- int_out  out  1  high while a sequence is active (to HDU `int`).
- count  out  2  sequence step counter (to HDU `count`).
- mem_write  out  1  stack write strobe.
- sp_dec  out  1  decrement SP after this write; equals mem_write.
- wr_data  out  DATA_W  stack write data.
- pc_load  out  1  one-cycle PC redirect strobe.
- pc_next  out  PC_W  redirect target (VEC_ADDR when pc_load).
- int_ack  out  1  one-cycle pulse when the sequence completes.

Behaviour:
- Reset: all outputs 0; state IDLE; pending=0; edge register req_q=0. A high int_req on the first cycle after reset is therefore an edge.
- Edge detect: edge = int_req & ~req_q. req_q is updated every cycle, including during stalls.
- Pending latch:
  - Set on edge.
  - Cleared on the cycle the sequence leaves IDLE.
  - Holds at most one request; further edges while pending=1 are dropped.
  - Level held high does not retrigger.
- States (count value in brackets; int_out=1 in all non-IDLE states):
  - IDLE [0]: if (pending | edge) & ~stall_in, capture pc_in into pc_r and flags_in into fl_r, then go to PUSH_HI. Else stay.
  - PUSH_HI [3]: mem_write=sp_dec=1, wr_data=pc_r[PC_W-1:DATA_W]. Then go to PUSH_LO.
  - PUSH_LO [2]: mem_write=sp_dec=1, wr_data=pc_r[DATA_W-1:0]. Then go to PUSH_FL.
  - PUSH_FL [1]: mem_write=sp_dec=1, wr_data={zeros,fl_r}. Then go to VECTOR.
  - VECTOR [0]: pc_load=1, pc_next=VEC_ADDR, int_ack=1. Then go to IDLE.
  - count and int_out are registered state decodes (no combinational path from inputs). In IDLE, int_out=0 and count=0.
- Latency:
  - Edge sampled in cycle N → PUSH_HI in N+1 → pc_load in N+4.
  - Total 4 active cycles with no stalls.
- stall_in in a non-IDLE state:
  - State, count, pc_r and fl_r hold.
  - mem_write, sp_dec, pc_load and int_ack are forced 0 that cycle; wr_data holds.
  - The step executes on the first unstalled cycle, so each push is issued exactly once.
- Edge during active sequence: sets pending. The new sequence starts from IDLE on the cycle after VECTOR, so there is at least one IDLE cycle between sequences.
- Edge coincident with leaving IDLE: consumed by that start; pending stays 0.
- Reset mid-sequence: immediate return to IDLE, pending cleared, no further strobes. Partial pushes are not undone.
- pc_next is 0 outside VECTOR.

Test Plan:
- Basic entry: pc_in=32'h0000_1234, flags_in=3'b101; pulse int_req 1 cycle → next 4 cycles: count 3,2,1,0; wr_data 16'h0000, 16'h1234, 16'h0005; mem_write=sp_dec=1 on three cycles; then pc_load=1, pc_next=VEC_ADDR, int_ack=1 on one cycle; int_out=1 for 4 cycles.
- Stall mid-sequence: stall_in=1 for 2 cycles while in PUSH_LO → count stays 2, mem_write=0 during stall, exactly one write of 16'h1234 afterwards, pc_load delayed by 2 cycles.
- Queued interrupt: second int_req edge during PUSH_FL → after VECTOR, one IDLE cycle, then a second full sequence. A third edge during the first sequence is dropped (exactly 2 int_ack pulses).
- Level hold: int_req held high 20 cycles → exactly one sequence, one int_ack.
- Reset mid-sequence: assert rst in PUSH_LO → next cycle all outputs 0, count=0, int_out=0; no pc_load follows; a new edge afterwards runs a clean sequence.
- Stalled start: pending=1 with stall_in=1 in IDLE for 3 cycles → stays IDLE, count=0. Starts the cycle stall_in drops, capturing pc_in and flags_in from that cycle.
